// File: rtl/sram_bridge_pkg.sv
// Shared definitions for the byte-lane SRAM bridge.
//   state_t       : bridge FSM states
//   lanes_of/lb_of: lane count and lane-select width for a given SRAM word width
//   extract_byte  : pick one byte lane out of a word
//   insert_byte   : overwrite one byte lane of a word
//   lane_sel      : one-hot lane enable for a lane index
// The byte helpers work on a 32-bit word so that both 16- and 32-bit
// configurations share them; callers cast to/from their own width.
package sram_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    RMW_RD,
    WR
  } state_t;

  function automatic int lanes_of(input int word_w);
    return word_w / 8;
  endfunction

  function automatic int lb_of(input int word_w);
    return (word_w > 16) ? 2 : 1;
  endfunction

  function automatic logic [7:0] extract_byte(input logic [31:0] word,
                                              input logic [1:0]  lane);
    return word[{lane, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [7:0]  data);
    logic [31:0] result;
    result = word;
    result[{lane, 3'b000} +: 8] = data;
    return result;
  endfunction

  function automatic logic [3:0] lane_sel(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/sram_lane_bridge_cache.sv
// One-word read-back cache for the SRAM lane bridge.
// Ports:
//   clk, reset      : system clock, synchronous active-high reset (clears valid)
//   inv             : clear the valid bit; beats a load in the same cycle
//   lookup_tag      : word address to compare against; hit/data are combinational
//   load            : replace the whole entry with upd_tag/load_data
//   lane_wr         : overwrite one lane if the entry is valid and tag == upd_tag
//   upd_tag         : word address for load and lane_wr
//   lane, lane_byte : lane index and byte used by lane_wr
module sram_word_cache
#(
  parameter int TAG_W  = 18,
  parameter int DATA_W = 16,
  parameter int LB     = 1
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              inv,
  input  logic [TAG_W-1:0]  lookup_tag,
  output logic              hit,
  output logic [DATA_W-1:0] data,
  input  logic              load,
  input  logic              lane_wr,
  input  logic [TAG_W-1:0]  upd_tag,
  input  logic [DATA_W-1:0] load_data,
  input  logic [LB-1:0]     lane,
  input  logic [7:0]        lane_byte
);

  logic             valid;
  logic [TAG_W-1:0] tag;

  assign hit = valid && (tag == lookup_tag);

  // A lane write only touches the entry when it already mirrors that word,
  // so a write to some other word can never corrupt the cached copy.
  // The invalidate is applied last so it wins over a load in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else begin
      if (load) begin
        valid <= 1'b1;
        tag   <= upd_tag;
        data  <= load_data;
      end else if (lane_wr && valid && (tag == upd_tag)) begin
        data[{lane, 3'b000} +: 8] <= lane_byte;
      end
      if (inv) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sram_lane_bridge.sv
// Bridges byte-wide CPU accesses onto a 16- or 32-bit SRAM controller.
// Handles lane selection, read-modify-write for controllers without byte
// enables, and serves byte reads from a one-word read-back cache.
// Ports:
//   clk, reset           : system clock, synchronous active-high reset
//   cpu_addr/cpu_wdata   : byte address and write byte, stable while cpu_req
//   cpu_req/cpu_we       : request and direction (1 = write)
//   cpu_rdata/cpu_ack    : read byte (held until next ack), one-cycle ack
//   cache_inv            : drop the cached word
//   sram_address         : word address to the controller
//   sram_data_write      : write word (merged word or replicated byte)
//   sram_be              : lane enables (all ones for read-modify-write)
//   sram_read/sram_write : strobes held until sram_ready
//   sram_data_read       : read word, valid with sram_ready
//   sram_ready           : one-cycle controller completion
module sram_lane_bridge
  import sram_bridge_pkg::*;
#(
  parameter int ADDR_W   = 19,
  parameter int SRAM_W   = 16,
  parameter int BYTE_EN  = 0,
  parameter int CACHE_EN = 1
)
(
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDR_W-1:0]              cpu_addr,
  input  logic [7:0]                     cpu_wdata,
  input  logic                           cpu_req,
  input  logic                           cpu_we,
  output logic [7:0]                     cpu_rdata,
  output logic                           cpu_ack,
  input  logic                           cache_inv,
  output logic [ADDR_W-lb_of(SRAM_W)-1:0] sram_address,
  output logic [SRAM_W-1:0]              sram_data_write,
  output logic [lanes_of(SRAM_W)-1:0]    sram_be,
  output logic                           sram_read,
  output logic                           sram_write,
  input  logic [SRAM_W-1:0]              sram_data_read,
  input  logic                           sram_ready
);

  localparam int LANES  = lanes_of(SRAM_W);
  localparam int LB     = lb_of(SRAM_W);
  localparam int WORD_W = ADDR_W - LB;

  state_t             state;
  logic [LB-1:0]      lane_q;
  logic [7:0]         wbyte_q;

  logic [LB-1:0]      req_lane;
  logic [WORD_W-1:0]  req_word;
  logic [1:0]         req_lane2;
  logic [1:0]         lane_q2;

  logic               cache_hit_raw;
  logic               cache_hit;
  logic [SRAM_W-1:0]  cache_data;
  logic               cache_load;
  logic               cache_lane_wr;
  logic [SRAM_W-1:0]  cache_load_data;

  logic [SRAM_W-1:0]  merged_rd;
  logic [SRAM_W-1:0]  merged_hit;
  logic [LANES-1:0]   be_req;

  assign req_lane  = cpu_addr[LB-1:0];
  assign req_word  = cpu_addr[ADDR_W-1:LB];
  assign req_lane2 = 2'(req_lane);
  assign lane_q2   = 2'(lane_q);

  assign cache_hit  = (CACHE_EN != 0) && cache_hit_raw;
  assign merged_rd  = SRAM_W'(insert_byte(32'(sram_data_read), lane_q2, wbyte_q));
  assign merged_hit = SRAM_W'(insert_byte(32'(cache_data), req_lane2, cpu_wdata));
  assign be_req     = LANES'(lane_sel(req_lane2));

  // Decide how a completing SRAM phase refreshes the cache: reads and
  // read-modify-write phases reload the whole word, a byte-enable write only
  // patches its lane (and only if that word is already cached).
  always_comb begin
    cache_load      = 1'b0;
    cache_lane_wr   = 1'b0;
    cache_load_data = sram_data_read;
    if (sram_ready) begin
      case (state)
        RD: begin
          cache_load = 1'b1;
        end
        RMW_RD: begin
          cache_load      = 1'b1;
          cache_load_data = merged_rd;
        end
        WR: begin
          if (BYTE_EN != 0) begin
            cache_lane_wr = 1'b1;
          end else begin
            cache_load      = 1'b1;
            cache_load_data = sram_data_write;
          end
        end
        default: begin
        end
      endcase
    end
    if (CACHE_EN == 0) begin
      cache_load    = 1'b0;
      cache_lane_wr = 1'b0;
    end
  end

  sram_word_cache #(
    .TAG_W (WORD_W),
    .DATA_W(SRAM_W),
    .LB    (LB)
  ) u_cache (
    .clk       (clk),
    .reset     (reset),
    .inv       (cache_inv),
    .lookup_tag(req_word),
    .hit       (cache_hit_raw),
    .data      (cache_data),
    .load      (cache_load),
    .lane_wr   (cache_lane_wr),
    .upd_tag   (sram_address),
    .load_data (cache_load_data),
    .lane      (lane_q),
    .lane_byte (wbyte_q)
  );

  // Main bridge FSM. A request is only taken in IDLE and never in the cycle
  // that is already acknowledging the previous one, since the CPU still holds
  // cpu_req during its ack cycle. Address, lane and write byte are captured
  // on entry to any SRAM phase so the controller sees stable operands.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      cpu_ack         <= 1'b0;
      cpu_rdata       <= '0;
      sram_read       <= 1'b0;
      sram_write      <= 1'b0;
      sram_address    <= '0;
      sram_data_write <= '0;
      sram_be         <= '0;
      lane_q          <= '0;
      wbyte_q         <= '0;
    end else begin
      cpu_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req && !cpu_ack) begin
            if (!cpu_we && cache_hit) begin
              cpu_rdata <= extract_byte(32'(cache_data), req_lane2);
              cpu_ack   <= 1'b1;
            end else begin
              sram_address <= req_word;
              lane_q       <= req_lane;
              wbyte_q      <= cpu_wdata;
              if (!cpu_we) begin
                sram_read <= 1'b1;
                sram_be   <= '1;
                state     <= RD;
              end else if (BYTE_EN != 0) begin
                sram_data_write <= {LANES{cpu_wdata}};
                sram_be         <= be_req;
                sram_write      <= 1'b1;
                state           <= WR;
              end else if (cache_hit) begin
                sram_data_write <= merged_hit;
                sram_be         <= '1;
                sram_write      <= 1'b1;
                state           <= WR;
              end else begin
                sram_read <= 1'b1;
                sram_be   <= '1;
                state     <= RMW_RD;
              end
            end
          end
        end
        RD: begin
          if (sram_ready) begin
            sram_read <= 1'b0;
            cpu_rdata <= extract_byte(32'(sram_data_read), lane_q2);
            cpu_ack   <= 1'b1;
            state     <= IDLE;
          end
        end
        RMW_RD: begin
          if (sram_ready) begin
            sram_read       <= 1'b0;
            sram_data_write <= merged_rd;
            sram_write      <= 1'b1;
            state           <= WR;
          end
        end
        WR: begin
          if (sram_ready) begin
            sram_write <= 1'b0;
            cpu_ack    <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_lane_bridge.sv
// Testbench for sram_lane_bridge. Two instances are exercised: A is the
// 16-bit read-modify-write configuration, B the 32-bit byte-enable one.
// The bench plays the SRAM controller (byte-addressed backing store with a
// programmable ready latency) and predicts results from a byte-level memory
// model plus a "which word is cached" model.
module tb_sram_lane_bridge;

  logic        clk;
  logic        reset;

  logic [18:0] a_addr;
  logic [7:0]  a_wdata;
  logic        a_req;
  logic        a_we;
  logic [7:0]  a_rdata;
  logic        a_ack;
  logic        a_inv;
  logic [17:0] a_saddr;
  logic [15:0] a_sdw;
  logic [1:0]  a_be;
  logic        a_srd;
  logic        a_swr;
  logic [15:0] a_sdr;
  logic        a_rdy;

  logic [18:0] b_addr;
  logic [7:0]  b_wdata;
  logic        b_req;
  logic        b_we;
  logic [7:0]  b_rdata;
  logic        b_ack;
  logic        b_inv;
  logic [16:0] b_saddr;
  logic [31:0] b_sdw;
  logic [3:0]  b_be;
  logic        b_srd;
  logic        b_swr;
  logic [31:0] b_sdr;
  logic        b_rdy;

  int          errors = 0;
  int          checks = 0;
  int          totalRd [2];
  logic [31:0] lastWr;
  logic [31:0] lastBe;

  bit          cvalid [2];
  int          cword  [2];

  logic [7:0]  smemA [int];
  logic [7:0]  smemB [int];
  logic [7:0]  refA  [int];
  logic [7:0]  refB  [int];

  logic        curB;
  logic        v_ack;
  logic        v_rd;
  logic        v_wr;
  logic [31:0] v_saddr;
  logic [31:0] v_sdw;
  logic [31:0] v_be;
  logic [31:0] v_rdata;

  sram_lane_bridge #(.ADDR_W(19), .SRAM_W(16), .BYTE_EN(0), .CACHE_EN(1)) dutA (
    .clk(clk), .reset(reset),
    .cpu_addr(a_addr), .cpu_wdata(a_wdata), .cpu_req(a_req), .cpu_we(a_we),
    .cpu_rdata(a_rdata), .cpu_ack(a_ack), .cache_inv(a_inv),
    .sram_address(a_saddr), .sram_data_write(a_sdw), .sram_be(a_be),
    .sram_read(a_srd), .sram_write(a_swr),
    .sram_data_read(a_sdr), .sram_ready(a_rdy)
  );

  sram_lane_bridge #(.ADDR_W(19), .SRAM_W(32), .BYTE_EN(1), .CACHE_EN(1)) dutB (
    .clk(clk), .reset(reset),
    .cpu_addr(b_addr), .cpu_wdata(b_wdata), .cpu_req(b_req), .cpu_we(b_we),
    .cpu_rdata(b_rdata), .cpu_ack(b_ack), .cache_inv(b_inv),
    .sram_address(b_saddr), .sram_data_write(b_sdw), .sram_be(b_be),
    .sram_read(b_srd), .sram_write(b_swr),
    .sram_data_read(b_sdr), .sram_ready(b_rdy)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // View of whichever instance the current access targets.
  assign v_ack   = curB ? b_ack : a_ack;
  assign v_rd    = curB ? b_srd : a_srd;
  assign v_wr    = curB ? b_swr : a_swr;
  assign v_saddr = curB ? 32'(b_saddr) : 32'(a_saddr);
  assign v_sdw   = curB ? b_sdw : 32'(a_sdw);
  assign v_be    = curB ? 32'(b_be) : 32'(a_be);
  assign v_rdata = curB ? 32'(b_rdata) : 32'(a_rdata);

  function automatic logic [7:0] initByte(input bit sel, input int a);
    return 8'((a * 37 + 11 + (sel ? 101 : 0)) ^ (a >>> 3));
  endfunction

  // isRef=0 selects the SRAM backing store, isRef=1 the CPU-visible model.
  function automatic logic [7:0] memRd(input bit isRef, input bit sel, input int a);
    if (!isRef && !sel && smemA.exists(a)) return smemA[a];
    if (!isRef &&  sel && smemB.exists(a)) return smemB[a];
    if ( isRef && !sel && refA.exists(a))  return refA[a];
    if ( isRef &&  sel && refB.exists(a))  return refB[a];
    return initByte(sel, a);
  endfunction

  function automatic void memWr(input bit isRef, input bit sel, input int a, input logic [7:0] v);
    if (!isRef && !sel) smemA[a] = v;
    else if (!isRef) smemB[a] = v;
    else if (!sel) refA[a] = v;
    else refB[a] = v;
  endfunction

  function automatic logic [31:0] memWord(input bit isRef, input bit sel, input int w);
    logic [31:0] r;
    int lanes;
    lanes = sel ? 4 : 2;
    r = '0;
    for (int i = 0; i < lanes; i++) r[8*i +: 8] = memRd(isRef, sel, w * lanes + i);
    return r;
  endfunction

  task automatic poke(input bit sel, input int a, input logic [7:0] v);
    memWr(0, sel, a, v);
    memWr(1, sel, a, v);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic driveReq(input bit sel, input bit req, input bit we, input int addr,
                          input logic [7:0] wd, input bit inv);
    if (sel) begin
      b_req = req; b_we = we; b_addr = 19'(addr); b_wdata = wd; b_inv = inv;
    end else begin
      a_req = req; a_we = we; a_addr = 19'(addr); a_wdata = wd; a_inv = inv;
    end
  endtask

  task automatic driveRdy(input bit sel, input bit rdy, input logic [31:0] d);
    if (sel) begin
      b_rdy = rdy; b_sdr = d;
    end else begin
      a_rdy = rdy; a_sdr = 16'(d);
    end
  endtask

  task automatic pulseInvalidate(input bit sel);
    if (sel) b_inv = 1'b1; else a_inv = 1'b1;
    @(negedge clk);
    if (sel) b_inv = 1'b0; else a_inv = 1'b0;
    cvalid[sel] = 1'b0;
  endtask

  // One complete CPU access: predicts the outcome, runs the request while
  // acting as the SRAM controller (ready after 'lat' strobe cycles), checks
  // the result, then holds the request through the ack cycle to make sure
  // it is not taken a second time.
  task automatic applyStimulus(input bit sel, input bit we, input int addr,
                               input logic [7:0] wd, input int lat, input bit inv);
    int lanes, word, lane, cycles, cnt, rdPh, wrPh, expRd, expWr, expLat;
    bit hit, got, prevRd, prevWr;
    logic [7:0]  expByte;
    logic [31:0] expWord;
    lanes   = sel ? 4 : 2;
    word    = addr / lanes;
    lane    = addr % lanes;
    hit     = cvalid[sel] && (cword[sel] == word);
    expByte = memRd(1, sel, addr);
    if (!we) begin
      expRd = hit ? 0 : 1; expWr = 0; expLat = hit ? 1 : 1 + lat;
    end else if (sel) begin
      expRd = 0; expWr = 1; expLat = 1 + lat;
    end else begin
      expRd = hit ? 0 : 1; expWr = 1; expLat = hit ? 1 + lat : 2 * lat + 1;
    end
    if (we) memWr(1, sel, addr, wd);
    expWord = memWord(1, sel, word);
    if (!we || !sel) begin
      cvalid[sel] = 1'b1;
      cword[sel]  = word;
    end
    if (inv) cvalid[sel] = 1'b0;

    curB = sel;
    driveReq(sel, 1'b1, we, addr, wd, inv);
    lastWr = '0; lastBe = '0;
    cycles = 0; cnt = 0; rdPh = 0; wrPh = 0; got = 0; prevRd = 0; prevWr = 0;
    while (!got && cycles < 60) begin
      @(negedge clk);
      cycles++;
      driveRdy(sel, 1'b0, '0);
      if (v_ack) begin
        got = 1'b1;
      end else if (v_rd || v_wr) begin
        if (v_rd && !prevRd) begin rdPh++; cnt = 0; end
        if (v_wr && !prevWr) begin wrPh++; cnt = 0; end
        cnt++;
        if (cnt == lat) begin
          checkOutput("sram_address", v_saddr, 32'(word));
          if (v_rd) begin
            driveRdy(sel, 1'b1, memWord(0, sel, word));
          end else begin
            lastWr = v_sdw;
            lastBe = v_be;
            for (int i = 0; i < lanes; i++)
              if (v_be[i]) memWr(0, sel, word * lanes + i, v_sdw[8*i +: 8]);
            driveRdy(sel, 1'b1, '0);
          end
        end
      end
      prevRd = v_rd;
      prevWr = v_wr;
    end
    totalRd[sel] += rdPh;

    checkOutput("ack_seen", 32'(got), 32'd1);
    checkOutput("latency", 32'(cycles), 32'(expLat));
    checkOutput("read_phases", 32'(rdPh), 32'(expRd));
    checkOutput("write_phases", 32'(wrPh), 32'(expWr));
    if (!we) begin
      checkOutput("cpu_rdata", v_rdata, 32'(expByte));
    end else if (sel) begin
      checkOutput("sram_be", lastBe, 32'(1) << lane);
      checkOutput("sram_data_write", lastWr, {4{wd}});
    end else begin
      checkOutput("sram_be", lastBe, 32'h3);
      checkOutput("sram_data_write", lastWr, expWord);
    end

    @(negedge clk);
    driveRdy(sel, 1'b0, '0);
    checkOutput("no_resample", {29'd0, v_ack, v_rd, v_wr}, 32'd0);
    driveReq(sel, 1'b0, 1'b0, 0, 8'h00, 1'b0);
  endtask

  // Directed test-plan steps followed by a randomized mix over both instances.
  initial begin
    int rd0;
    bit ok;
    reset = 1'b1; curB = 1'b0;
    totalRd[0] = 0; totalRd[1] = 0;
    cvalid[0] = 1'b0; cvalid[1] = 1'b0; cword[0] = 0; cword[1] = 0;
    driveReq(0, 1'b1, 1'b0, 'h11, 8'h00, 1'b0);
    driveReq(1, 1'b1, 1'b0, 'h11, 8'h00, 1'b0);
    driveRdy(0, 1'b0, '0);
    driveRdy(1, 1'b0, '0);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("reset_strobes_ack", {26'd0, a_srd, a_swr, a_ack, b_srd, b_swr, b_ack}, 32'd0);
    end
    checkOutput("reset_A_outputs", {6'd0, a_rdata, a_be, a_sdw}, 32'd0);
    checkOutput("reset_A_address", 32'(a_saddr), 32'd0);
    checkOutput("reset_B_outputs", {20'd0, b_rdata, b_be}, 32'd0);
    checkOutput("reset_B_data", b_sdw, 32'd0);
    checkOutput("reset_B_address", 32'(b_saddr), 32'd0);
    reset = 1'b0;
    driveReq(0, 1'b0, 1'b0, 0, 8'h00, 1'b0);
    driveReq(1, 1'b0, 1'b0, 0, 8'h00, 1'b0);
    $display("[TB] reset released");

    poke(0, 'h10, 8'hEF);
    poke(0, 'h11, 8'hBE);
    applyStimulus(0, 0, 'h11, 8'h00, 2, 0);
    checkOutput("tp_first_read", 32'(a_rdata), 32'hBE);
    applyStimulus(0, 0, 'h10, 8'h00, 1, 0);
    checkOutput("tp_hit_read", 32'(a_rdata), 32'hEF);
    pulseInvalidate(0);
    applyStimulus(0, 0, 'h10, 8'h00, 1, 0);

    poke(0, 'h08, 8'h34);
    poke(0, 'h09, 8'h12);
    applyStimulus(0, 1, 'h09, 8'h5A, 1, 0);
    checkOutput("tp_rmw_word", lastWr, 32'h5A34);
    applyStimulus(0, 0, 'h08, 8'h00, 1, 0);
    checkOutput("tp_rmw_hit_read", 32'(a_rdata), 32'h34);

    applyStimulus(1, 1, 'h06, 8'hC3, 2, 0);
    checkOutput("tp_be_lanes", lastBe, 32'h4);
    checkOutput("tp_be_data", lastWr, 32'hC3C3C3C3);
    applyStimulus(1, 0, 'h06, 8'h00, 1, 0);

    applyStimulus(0, 1, 'h7FFFF, 8'hA5, 1, 0);
    applyStimulus(0, 0, 'h7FFFF, 8'h00, 1, 0);
    applyStimulus(0, 0, 'h7FFFE, 8'h00, 1, 1);

    // Abandon a byte-enable write that never gets its ready.
    $display("[TB] reset during write phase");
    curB = 1'b1;
    driveReq(1, 1'b1, 1'b1, 'h20, 8'h77, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = b_swr;
    end
    checkOutput("midop_write_started", 32'(ok), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    driveReq(1, 1'b0, 1'b0, 0, 8'h00, 1'b0);
    @(negedge clk);
    checkOutput("midop_strobe_dropped", {30'd0, b_swr, b_ack}, 32'd0);
    reset = 1'b0;
    cvalid[0] = 1'b0; cvalid[1] = 1'b0;
    driveRdy(0, 1'b1, 32'hDEADBEEF);
    driveRdy(1, 1'b1, 32'hDEADBEEF);
    @(negedge clk);
    driveRdy(0, 1'b0, '0);
    driveRdy(1, 1'b0, '0);
    checkOutput("late_ready_ignored", {26'd0, a_srd, a_swr, a_ack, b_srd, b_swr, b_ack}, 32'd0);
    applyStimulus(1, 0, 'h20, 8'h00, 1, 0);
    applyStimulus(1, 1, 'h20, 8'h77, 1, 0);
    applyStimulus(1, 0, 'h21, 8'h00, 1, 0);

    $display("[TB] back-to-back reads");
    rd0 = totalRd[0];
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 'h100 + i, 8'h00, 1, 0);
    checkOutput("b2b_sram_reads", 32'(totalRd[0] - rd0), 32'd2);

    $display("[TB] randomized accesses");
    for (int i = 0; i < 120; i++) begin
      bit sel, we, inv;
      int addr;
      sel  = 1'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      inv  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) addr = 'h7FFFF - int'($urandom_range(0, 7));
      else addr = int'($urandom_range(0, 23));
      applyStimulus(sel, we, addr, 8'($urandom), int'($urandom_range(1, 3)), inv);
      if ($urandom_range(0, 15) == 0) pulseInvalidate(sel);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
